pipeline_interlock: RTL

Stall/flush controller for the 5-stage MIPS pipeline; complements the forwarding unit by handling hazards that bypassing cannot resolve. Detects load-use and branch-operand hazards in ID, issues and waits on the multi-cycle mul/div unit, and generates PC / IF-ID write enables, IF-ID flush and ID-EXE bubble. Sits beside the forwarding unit and drives the pipeline registers and PC.

---
 rtl/pipeline_interlock.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipeline_interlock.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use and branch-operand
// interlocks in ID, mul/div issue-and-wait, and PC / IF-ID / ID-EXE control.
module pipeline_interlock #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64,
  parameter int TO_W       = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_is_branch,
  input  logic             ID_is_md,
  input  logic             branch_taken,
  input  logic [4:0]       EXE_num_write,
  input  logic             EXE_reg_write,
  input  logic             EXE_mem_read,
  input  logic [4:0]       MEM_num_write,
  input  logic             MEM_mem_read,
  input  logic             md_done,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EXE_bubble,
  output logic             md_start,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_error,
  output logic             dbg_state
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             md_error_q, md_error_d;

  logic src_hit_exe, src_hit_mem, load_use, br_haz, hazard, md_timeout;
  logic pc_write_c, if_id_write_c, if_id_flush_c, bubble_c, md_start_c;

  // Register $0 is hard-wired, so a zero source or destination never matches.
  assign src_hit_exe = (ID_use_rs && (rs == EXE_num_write) && (rs != 5'd0)) ||
                       (ID_use_rt && (rt == EXE_num_write) && (rt != 5'd0));
  assign src_hit_mem = (ID_use_rs && (rs == MEM_num_write) && (rs != 5'd0)) ||
                       (ID_use_rt && (rt == MEM_num_write) && (rt != 5'd0));

  assign load_use   = EXE_mem_read && src_hit_exe;
  assign br_haz     = ID_is_branch && ((EXE_reg_write && src_hit_exe) ||
                                       (MEM_mem_read && src_hit_mem));
  assign hazard     = load_use || br_haz;
  assign md_timeout = (to_cnt_q == TO_LAST);

  // md_start is a one-cycle issue pulse; md_done is a one-cycle completion pulse
  // honoured only in MD_WAIT. Whichever of md_done or the timeout comes first releases.
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    md_error_d    = md_error_q;
    pc_write_c    = 1'b0;
    if_id_write_c = 1'b0;
    if_id_flush_c = 1'b0;
    bubble_c      = 1'b1;
    md_start_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        to_cnt_d = '0;
        if (!hazard) begin
          if (ID_is_md) begin
            md_start_c = 1'b1;
            state_d    = ST_MD_WAIT;
          end else begin
            pc_write_c    = 1'b1;
            if_id_write_c = 1'b1;
            bubble_c      = 1'b0;
            if_id_flush_c = branch_taken && ID_is_branch;
          end
        end
      end
      ST_MD_WAIT: begin
        if (md_done || md_timeout) begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          bubble_c      = 1'b0;
          state_d       = ST_RUN;
          to_cnt_d      = '0;
          if (!md_done) md_error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        to_cnt_d = '0;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (!pc_write_c && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_RUN;
      to_cnt_q       <= '0;
      stall_cycles_q <= '0;
      md_error_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      md_error_q     <= md_error_d;
    end
  end

  // Reset overrides the control outputs combinationally so the pipeline freezes at once.
  assign PC_write      = resetn && pc_write_c;
  assign IF_ID_write   = resetn && if_id_write_c;
  assign IF_ID_flush   = resetn && if_id_flush_c;
  assign ID_EXE_bubble = !resetn || bubble_c;
  assign md_start      = resetn && md_start_c;
  assign stall_cycles  = stall_cycles_q;
  assign md_error      = md_error_q;
  assign dbg_state     = state_q[0];

endmodule
